// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetcher: issues in-order fetches, tags responses with their PC
// and queues {pc, instr} pairs for decode. Flush redirects and drops in-flight responses.
module instruction_prefetch_buffer #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     fetch_en_i,
   input  logic                     flush_i,
   input  logic [ADDR_WIDTH-1:0]    flush_pc_i,
   output logic                     inst_req_o,
   output logic [ADDR_WIDTH-1:0]    inst_addr_o,
   input  logic                     inst_gnt_i,
   input  logic                     inst_rvalid_i,
   input  logic [DATA_WIDTH-1:0]    inst_rdata_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [DATA_WIDTH-1:0]    instr_data_o,
   output logic [ADDR_WIDTH-1:0]    instr_pc_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 2;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  fetch_pc_q;
   logic [CW-1:0]          outstanding_q, discard_q, count_q;
   logic [PW-1:0]          tag_wr_q, tag_rd_q, wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH-1:0]  tag_mem [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_mem [DEPTH];
   logic [DATA_WIDTH-1:0]  data_mem [DEPTH];

   logic [SW-1:0]          credit_used;
   logic                   grant, resp_drop, resp_push, pop;

   // Every issued request reserves a FIFO slot, so a response never finds the FIFO full.
   assign credit_used = SW'(count_q) + SW'(outstanding_q) + SW'(discard_q);
   assign inst_req_o  = (state_q == RUN) && !flush_i && (credit_used < SW'(DEPTH));
   assign inst_addr_o = fetch_pc_q;

   assign grant     = inst_req_o && inst_gnt_i;
   assign resp_drop = inst_rvalid_i && (discard_q != '0);
   assign resp_push = inst_rvalid_i && (discard_q == '0) && !flush_i;
   assign pop       = (count_q != '0) && instr_ready_i && !flush_i;

   assign instr_valid_o = (count_q != '0);
   assign instr_data_o  = instr_valid_o ? data_mem[rd_ptr_q] : '0;
   assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q]   : '0;
   assign occupancy_o   = count_q;

   // A request already on the bus is held until granted, even with fetch disabled.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fetch_en_i) state_d = RUN;
         RUN:     if (!fetch_en_i && (!inst_req_o || inst_gnt_i)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q <= state_d;
         if (flush_i) begin
            // Everything still in flight becomes stale, except a response landing right now.
            fetch_pc_q    <= flush_pc_i;
            discard_q     <= discard_q + outstanding_q - CW'(inst_rvalid_i);
            outstanding_q <= '0;
            count_q       <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
         end else begin
            if (grant) begin
               fetch_pc_q <= fetch_pc_q + PC_STEP;
               tag_wr_q   <= tag_wr_q + PW'(1);
            end
            if (resp_drop) discard_q <= discard_q - CW'(1);
            if (resp_push) begin
               wr_ptr_q <= wr_ptr_q + PW'(1);
               tag_rd_q <= tag_rd_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            outstanding_q <= outstanding_q + CW'(grant) - CW'(resp_push);
            count_q       <= count_q + CW'(resp_push) - CW'(pop);
         end
      end
   end

   // ---- storage stage: granted-address tags and FIFO payload (no reset needed) ----
   always_ff @(posedge clk_i) begin
      if (grant) tag_mem[tag_wr_q] <= fetch_pc_q;
      if (resp_push) begin
         data_mem[wr_ptr_q] <= inst_rdata_i;
         pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
      end
   end

`ifndef SYNTHESIS
   a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
      inst_rvalid_i |-> ((outstanding_q + discard_q) != '0));
   a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inst_req_o && !inst_gnt_i) |=> (!inst_req_o || $stable(inst_addr_o)));
   a_occupancy: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CW'(DEPTH));
`endif

endmodule

// File: doc/instruction_prefetch_buffer.md
Name: instruction_prefetch_buffer

Overview:
Parametrised successor to the single-port instruction buffer. It autonomously fetches sequential instruction words from instruction memory over a req/gnt/rvalid interface, and queues {pc, instr} pairs in a DEPTH-entry FIFO. It hands those pairs to decode over a valid/ready handshake. It supports redirect (flush) with in-flight response discard, and sits between instruction memory and the decode stage.

Parameters:
DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
ADDR_WIDTH, 32, fetch address / PC width.
DEPTH, 4, FIFO entries and maximum outstanding requests; power of 2, minimum 2.
RESET_PC, 0, first fetch address after reset.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  asynchronous active-low reset.
fetch_en_i  input  1  high lets the block issue requests.
flush_i  input  1  redirect strobe.
flush_pc_i  input  ADDR_WIDTH  new fetch address, sampled when flush_i is high.
inst_req_o  output  1  fetch request.
inst_addr_o  output  ADDR_WIDTH  fetch address; held stable while req is high and gnt is low.
inst_gnt_i  input  1  request accepted this cycle.
inst_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after gnt.
inst_rdata_i  input  DATA_WIDTH  response data.
instr_valid_o  output  1  FIFO head valid.
instr_ready_i  input  1  decode accepts the head.
instr_data_o  output  DATA_WIDTH  head instruction.
instr_pc_o  output  ADDR_WIDTH  head PC.
occupancy_o  output  $clog2(DEPTH)+1  FIFO entries currently held.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state IDLE.
  - Outputs: inst_req_o=0, inst_addr_o=RESET_PC, instr_valid_o=0, instr_data_o=0, instr_pc_o=0, occupancy_o=0.
- FSM:
  - IDLE -> RUN when fetch_en_i=1.
  - RUN -> IDLE when fetch_en_i=0 and inst_req_o=0, or when fetch_en_i=0 and gnt arrives that cycle. A pending request is never withdrawn.
  - flush_i does not change state.
- Request rule:
  - inst_req_o = (state==RUN) & ~flush_i & (occupancy + outstanding + discard < DEPTH). This credit rule guarantees a response never finds the FIFO full.
  - inst_addr_o = fetch_pc.
  - On req&gnt: fetch_pc += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), and outstanding increments.
- Response:
  - When inst_rvalid_i=1 and discard>0: discard decrements and the data is dropped.
  - Otherwise: push {pc_tag, rdata} and decrement outstanding. pc_tag comes from an in-order DEPTH-entry queue of granted addresses.
- Output:
  - instr_valid_o = FIFO not empty; head fields are registered.
  - Latency: rvalid in cycle N -> instr_valid_o in cycle N+1. There is no bypass.
  - Pop on valid&ready. Push and pop in the same cycle leave occupancy unchanged. Head fields hold while valid&~ready.
- Flush (cycle F):
  - FIFO cleared and instr_valid_o=0 in F+1.
  - fetch_pc = flush_pc_i.
  - discard = discard + outstanding - (inst_rvalid_i ? 1 : 0); outstanding = 0. A response arriving in cycle F is dropped.
  - inst_req_o=0 in F; first new request no earlier than F+1 with addr=flush_pc_i.
  - Pop in cycle F is ignored.
  - Back-to-back flushes: the last one wins; discard accumulates correctly.
- Simultaneous flush_i and rst_ni low: reset wins.
- Reset mid-transaction: all counters are cleared. Any memory response arriving after reset release is not the block's concern; the system resets memory together with this block.
- Misaligned flush_pc_i is passed through unchanged; alignment checks belong to the branch unit.
- Assertions:
  - rvalid never arrives with outstanding+discard==0.
  - inst_addr_o is stable while req&~gnt.
  - occupancy_o <= DEPTH.

Test Plan:
- Reset, fetch_en_i=1, gnt always 1, rvalid 1 cycle after gnt, ready=1 -> addresses 0x0,0x4,0x8..., first instr_valid_o 3 cycles after enable, instr_pc_o matches the data tag.
- DEPTH=4, ready=0 -> exactly 4 grants, inst_req_o drops, occupancy_o=4. Then ready=1 for one cycle -> one pop, one new request to 0x10.
- Three requests outstanding with rvalid delayed 5 cycles, flush_i with flush_pc_i=0x100 -> the three late responses are dropped; first valid has instr_pc_o=0x100; no stale data is ever presented.
- Flush in the same cycle as rvalid and ready&valid -> the response is dropped, the pop is ignored, FIFO is empty next cycle, and discard equals outstanding-1.
- gnt withheld 3 cycles while fetch_en_i is deasserted -> inst_req_o and inst_addr_o are held until gnt, then the block goes IDLE with no further requests.
- rst_ni asserted asynchronously mid-burst with occupancy 2 -> all outputs reach reset values immediately. After release with fetch_en_i=1, fetch restarts at RESET_PC.
